// File: rtl/ysyx_23060077_riscv_ifu_pkg.sv
// Shared IFU definitions: FSM state codes, reset PC, NOP encoding, redirect sources.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_23060077_riscv_ifu_pkg;

  // Fetch FSM: IDLE after reset, REQ issuing, WAIT for response, HOLD for decode.
  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  // Which input won the redirect priority this cycle.
  typedef enum logic [1:0] {
    RDR_NONE  = 2'd0,
    RDR_ECALL = 2'd1,
    RDR_MRET  = 2'd2,
    RDR_BR    = 2'd3
  } redir_src_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  // addi x0, x0, 0 -- substituted for the payload of a faulting fetch.
  localparam logic [31:0] IFU_NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060077_riscv_pc_sel.sv
// Redirect priority mux: ecall > mret > branch, producing {redirect, target}.
// Latency: purely combinational.
// Backpressure: none; redirects are single-cycle pulses sampled by the IFU.
module ysyx_23060077_riscv_pc_sel
  import ysyx_23060077_riscv_ifu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_ecall,
  input  logic                  i_mret,
  input  logic                  i_br_taken,
  input  logic [DATA_WIDTH-1:0] i_br_target,
  input  logic [DATA_WIDTH-1:0] i_mtvec,
  input  logic [DATA_WIDTH-1:0] i_mepc,
  output logic                  redirect,
  output logic [DATA_WIDTH-1:0] target
);

  redir_src_e src;

  // Pick the winning source: trap entry beats trap return beats branch.
  always_comb begin
    if (i_ecall) begin
      src = RDR_ECALL;
    end else if (i_mret) begin
      src = RDR_MRET;
    end else if (i_br_taken) begin
      src = RDR_BR;
    end else begin
      src = RDR_NONE;
    end
  end

  // Route the winner's address; mtvec's low two bits are the mode field, not address.
  always_comb begin
    target = i_br_target;
    case (src)
      RDR_ECALL: target = {i_mtvec[DATA_WIDTH-1:2], 2'b00};
      RDR_MRET:  target = i_mepc;
      default:   target = i_br_target;
    endcase
  end

  assign redirect = (src != RDR_NONE);

endmodule

// File: rtl/ysyx_23060077_riscv_ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time, hands {pc, inst} to decode.
// Latency: REQ -> WAIT -> HOLD, one instruction per 3 cycles best case with zero-wait memory.
// Backpressure: waits in REQ on imem ready and holds outputs stable in HOLD until decode ready.
// Build option: define IFU_PERF_CNT_EN to add o_fetch_cnt / o_stall_cnt performance counters.
module ysyx_23060077_riscv_ifu
  import ysyx_23060077_riscv_ifu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(IFU_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ecall,
  input  logic                  i_mret,
  input  logic                  i_br_taken,
  input  logic [DATA_WIDTH-1:0] i_br_target,
  input  logic [DATA_WIDTH-1:0] i_mtvec,
  input  logic [DATA_WIDTH-1:0] i_mepc,
  output logic                  o_imem_req_valid,
  input  logic                  i_imem_req_ready,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] i_imem_rsp_data,
  input  logic                  i_imem_rsp_err,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_inst_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] o_fetch_cnt,
  output logic [DATA_WIDTH-1:0] o_stall_cnt
`endif
);

  localparam logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(IFU_NOP);

  ifu_state_e            state;
  logic [DATA_WIDTH-1:0] pc;
  logic                  kill;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  handshake;

  ysyx_23060077_riscv_pc_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_sel (
    .i_ecall     (i_ecall),
    .i_mret      (i_mret),
    .i_br_taken  (i_br_taken),
    .i_br_target (i_br_target),
    .i_mtvec     (i_mtvec),
    .i_mepc      (i_mepc),
    .redirect    (redirect),
    .target      (redirect_pc)
  );

  // The PC register is the fetch address; it only moves while no request is being held unaccepted
  // except on redirect, where the request deliberately re-issues at the new address.
  assign o_imem_addr = pc;
  assign pc_plus4    = pc + DATA_WIDTH'(4);
  assign handshake   = o_inst_valid & i_inst_ready;

  // Fetch FSM with registered request/decode outputs; kill marks an in-flight response as stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IFU_IDLE;
      pc               <= RESET_PC;
      kill             <= 1'b0;
      o_imem_req_valid <= 1'b0;
      o_inst_valid     <= 1'b0;
      o_inst           <= '0;
      o_pc             <= '0;
      o_inst_err       <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE: begin
          if (redirect) pc <= redirect_pc;
          state            <= IFU_REQ;
          o_imem_req_valid <= 1'b1;
        end

        IFU_REQ: begin
          if (redirect) pc <= redirect_pc;
          if (i_imem_req_ready) begin
            // A redirect racing the accept means the accepted address is already stale.
            state            <= IFU_WAIT;
            o_imem_req_valid <= 1'b0;
            kill             <= redirect;
          end
        end

        IFU_WAIT: begin
          if (redirect) pc <= redirect_pc;
          if (i_imem_rsp_valid) begin
            if (kill || redirect) begin
              kill             <= 1'b0;
              state            <= IFU_REQ;
              o_imem_req_valid <= 1'b1;
            end else begin
              o_inst       <= i_imem_rsp_err ? NOP_INST : i_imem_rsp_data;
              o_inst_err   <= i_imem_rsp_err;
              o_pc         <= pc;
              o_inst_valid <= 1'b1;
              state        <= IFU_HOLD;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end

        IFU_HOLD: begin
          // A redirect overrides sequential advance even when decode takes the instruction.
          if (redirect || handshake) begin
            pc               <= redirect ? redirect_pc : pc_plus4;
            o_inst_valid     <= 1'b0;
            state            <= IFU_REQ;
            o_imem_req_valid <= 1'b1;
          end
        end

        default: begin
          state <= IFU_IDLE;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Count delivered instructions and cycles lost waiting on instruction memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_fetch_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (handshake) o_fetch_cnt <= o_fetch_cnt + DATA_WIDTH'(1);
      if ((state == IFU_REQ && !i_imem_req_ready) || (state == IFU_WAIT && !i_imem_rsp_valid))
        o_stall_cnt <= o_stall_cnt + DATA_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060077_riscv_ifu.sv
// Scoreboard bench for the IFU: a memory model answers fetches, an architectural PC model predicts deliveries.
// Inputs change on the falling edge; the monitor samples 1ns after the rising edge.
// Directed plan items run first, then a randomized phase with random stalls and redirects.
module tb_ysyx_23060077_riscv_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ecall, i_mret, i_br_taken;
  logic [31:0] i_br_target, i_mtvec, i_mepc;
  logic        o_imem_req_valid, i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_imem_rsp_err;
  logic        o_inst_valid, i_inst_ready;
  logic [31:0] o_inst, o_pc;
  logic        o_inst_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] o_fetch_cnt, o_stall_cnt;
`endif

  ysyx_23060077_riscv_ifu dut (
`ifdef IFU_PERF_CNT_EN
    .o_fetch_cnt      (o_fetch_cnt),
    .o_stall_cnt      (o_stall_cnt),
`endif
    .clk              (clk),
    .rst_n            (rst_n),
    .i_ecall          (i_ecall),
    .i_mret           (i_mret),
    .i_br_taken       (i_br_taken),
    .i_br_target      (i_br_target),
    .i_mtvec          (i_mtvec),
    .i_mepc           (i_mepc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_imem_rsp_err   (i_imem_rsp_err),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst           (o_inst),
    .o_pc             (o_pc),
    .o_inst_err       (o_inst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_deliv = 0;
  logic [31:0] last_pc, last_inst;
  logic        last_err;

  // architectural model: next PC decode should see, and whether an expected entry is still in flight
  logic [31:0] arch_pc;
  bit          inflight;

  // memory model: one outstanding request, answered after a random delay
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          min_lat, max_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0093;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[17:2]};
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a[7:2] == 6'h0B);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory response, acceptance and architectural model for the coming rising edge.
  task automatic commit();
    logic        rd, acc;
    logic [31:0] tgt;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = $urandom;
    i_imem_rsp_err   = 1'($urandom_range(1));
    if (mem_busy) begin
      if (mem_wait == 0) begin
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = mem_word(mem_addr);
        i_imem_rsp_err   = mem_err(mem_addr);
        mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end
    acc = o_imem_req_valid && i_imem_req_ready;
    if (acc) begin
      mem_busy = 1;
      mem_addr = o_imem_addr;
      mem_wait = $urandom_range(max_lat, min_lat);
    end
    rd  = i_ecall | i_mret | i_br_taken;
    tgt = i_ecall ? (i_mtvec & ~32'h3) : (i_mret ? i_mepc : i_br_target);
    if (rd) begin
      // anything fetched but not yet shown to decode is discarded by a redirect
      if (inflight) begin
        void'(exp_q.pop_back());
        inflight = 0;
      end
      arch_pc = tgt;
    end else begin
      if (i_imem_rsp_valid) inflight = 0;
      if (acc) begin
        exp_q.push_back('{pc: arch_pc,
                          inst: mem_err(arch_pc) ? NOP : mem_word(arch_pc),
                          err: mem_err(arch_pc)});
        inflight = 1;
      end
      if (o_inst_valid && i_inst_ready) arch_pc = arch_pc + 32'd4;
    end
  endtask

  // Called at a falling edge; applies one cycle of inputs and returns at the next falling edge.
  task automatic cyc(input bit rr, input bit ir, input bit e, input bit m, input bit b);
    i_imem_req_ready = rr;
    i_inst_ready     = ir;
    i_ecall          = e;
    i_mret           = m;
    i_br_taken       = b;
    commit();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit stale);
    rst_n = 1'b0;
    i_ecall = 0; i_mret = 0; i_br_taken = 0;
    i_imem_req_ready = 0; i_inst_ready = 0; i_imem_rsp_valid = 0;
    i_imem_rsp_data = '0; i_imem_rsp_err = 0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_inst_err", 32'(o_inst_err), 32'd0);
    exp_q.delete();
    inflight = 0;
    arch_pc  = RST_PC;
    mem_busy = stale;
    mem_addr = 32'hDEAD_BEE0;
    mem_wait = 0;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("req_after_idle", 32'(o_imem_req_valid), 32'd1);
    check("first_fetch_addr", o_imem_addr, RST_PC);
  endtask

  task automatic run_deliveries(input int n, input int budget, input string name);
    int target;
    int k;
    target = n_deliv + n;
    k = 0;
    while (n_deliv < target && k < budget) begin
      cyc(1, 1, 0, 0, 0);
      k++;
    end
    if (n_deliv < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout, %0d deliveries seen, expected %0d", name, n_deliv, target);
    end
  endtask

  task automatic run_until_req(input int budget, input string name, input logic [31:0] exp_addr);
    int k;
    k = 0;
    while (!o_imem_req_valid && k < budget) begin
      cyc(0, 1, 0, 0, 0);
      k++;
    end
    if (!o_imem_req_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout waiting for fetch request, expected addr %h", name, exp_addr);
    end else begin
      check(name, o_imem_addr, exp_addr);
    end
  endtask

  // Monitor: each new delivery pops the scoreboard; held cycles must keep matching it.
  initial begin : monitor
    bit   prev_v;
    exp_t cur;
    prev_v = 0;
    cur    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_v = 0;
      end else begin
        if (o_inst_valid) begin
          if (!prev_v) begin
            n_deliv++;
            last_pc   = o_pc;
            last_inst = o_inst;
            last_err  = o_inst_err;
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_delivery: got pc %h, scoreboard expected nothing", o_pc);
              cur = '{pc: o_pc, inst: o_inst, err: o_inst_err};
            end else begin
              cur = exp_q.pop_front();
            end
          end
          check("dec_pc", o_pc, cur.pc);
          check("dec_inst", o_inst, cur.inst);
          check("dec_err", 32'(o_inst_err), 32'(cur.err));
          check("no_req_in_hold", 32'(o_imem_req_valid), 32'd0);
        end
        prev_v = o_inst_valid;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] hold_pc, hold_inst;
    logic [2:0]  r;
    bit          e, m, b;
    int          d0;
    rst_n = 1'b0;
    i_br_target = '0; i_mtvec = '0; i_mepc = '0;
    min_lat = 0; max_lat = 0;

    // zero-wait first fetch, then sequential +4
    do_reset(0);
    run_deliveries(1, 20, "first_delivery");
    check("first_pc", last_pc, 32'h8000_0000);
    check("first_inst", last_inst, 32'h0000_0093);
    run_until_req(10, "seq_next_addr", 32'h8000_0004);

    // branch while the request is stalled by memory
    do_reset(0);
    cyc(0, 1, 0, 0, 0);
    i_br_target = 32'h8000_0100;
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    check("br_stalled_req_addr", o_imem_addr, 32'h8000_0100);
    run_deliveries(1, 20, "br_delivery");
    check("br_delivered_pc", last_pc, 32'h8000_0100);
    run_until_req(10, "after_br_addr", 32'h8000_0104);

    // ecall while a response is in flight
    min_lat = 2; max_lat = 2;
    cyc(1, 1, 0, 0, 0);
    i_mtvec = 32'h8000_0203;
    cyc(0, 1, 1, 0, 0);
    run_until_req(20, "ecall_fetch_addr", 32'h8000_0200);
    min_lat = 0; max_lat = 0;
    run_deliveries(1, 20, "ecall_delivery");
    check("ecall_delivered_pc", last_pc, 32'h8000_0200);

    // ecall and mret together: ecall wins
    run_until_req(10, "after_ecall_addr", 32'h8000_0204);
    i_mtvec = 32'h8000_1000;
    i_mepc  = 32'h8000_0040;
    cyc(0, 1, 1, 1, 0);
    check("ecall_over_mret_addr", o_imem_addr, 32'h8000_1000);
    run_deliveries(1, 20, "prio_delivery");
    check("prio_delivered_pc", last_pc, 32'h8000_1000);

    // decode stalls five cycles in HOLD
    hold_pc   = o_pc;
    hold_inst = o_inst;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("stall_pc_stable", o_pc, hold_pc);
      check("stall_inst_stable", o_inst, hold_inst);
      check("stall_valid_held", 32'(o_inst_valid), 32'd1);
    end
    run_until_req(10, "after_stall_addr", hold_pc + 32'd4);

    // access fault turns into a flagged NOP
    i_br_target = 32'h8000_002C;
    cyc(0, 1, 0, 0, 1);
    run_deliveries(1, 20, "err_delivery");
    check("err_inst_nop", last_inst, NOP);
    check("err_flag", 32'(last_err), 32'd1);

    // redirect coinciding with a decode handshake, then PC wrap
    i_br_target = 32'hFFFF_FFFC;
    cyc(0, 1, 0, 0, 1);
    run_deliveries(1, 20, "wrap_delivery");
    check("wrap_delivered_pc", last_pc, 32'hFFFF_FFFC);
    run_until_req(10, "wrap_next_addr", 32'h0000_0000);

    // reset with a response outstanding; the late response must be ignored
    min_lat = 3; max_lat = 3;
    cyc(1, 1, 0, 0, 0);
    do_reset(1);
    min_lat = 0; max_lat = 0;
    run_deliveries(1, 20, "post_reset_delivery");
    check("post_reset_pc", last_pc, RST_PC);
    check("post_reset_inst", last_inst, 32'h0000_0093);

    // randomized traffic
    min_lat = 0; max_lat = 3;
    d0 = n_deliv;
    for (int c = 0; c < 3000; c++) begin
      e = 0; m = 0; b = 0;
      if ($urandom_range(99) < 6) begin
        r = 3'($urandom_range(7, 1));
        e = r[0]; m = r[1]; b = r[2];
        i_mtvec     = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
        i_mepc      = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
        i_br_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8
                                               : (32'h8000_1000 | ($urandom & 32'h0000_0FFC));
      end
      cyc($urandom_range(99) < 70, $urandom_range(99) < 70, e, m, b);
    end
    check("random_progress", 32'(n_deliv - d0 >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
